// File: rtl/vga_sync_generator.sv
// VGA raster timing generator: divides clk down to a pixel tick and produces
// zero-skew registered coordinates, sync pulses, video_on and frame markers.
module vga_sync_generator #(
  parameter int CLK_DIV  = 4,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pix_tick,
  output logic [15:0] h_counter,
  output logic [15:0] v_counter,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        frame_start,
  output logic [7:0]  frame_count
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [15:0] H_LAST      = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST      = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_SYNC_END  = 16'(H_SYNC);
  localparam logic [15:0] V_SYNC_END  = 16'(V_SYNC);
  localparam logic [15:0] H_ACT_BEG   = 16'(H_SYNC + H_BP);
  localparam logic [15:0] H_ACT_END   = 16'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [15:0] V_ACT_BEG   = 16'(V_SYNC + V_BP);
  localparam logic [15:0] V_ACT_END   = 16'(V_SYNC + V_BP + V_ACTIVE);

  localparam logic [4:0]  DIV_LAST    = 5'(CLK_DIV - 1);

  logic [4:0]  div_cnt;
  logic [4:0]  div_next;
  logic [15:0] h_next;
  logic [15:0] v_next;
  logic        line_wrap;
  logic        frame_wrap;
  logic        h_vis_next;
  logic        v_vis_next;

  // Next-state coordinates; sync/video are derived from these so the
  // registered outputs always describe the coordinate being registered.
  always_comb begin
    div_next   = (div_cnt == DIV_LAST) ? 5'd0 : div_cnt + 5'd1;
    line_wrap  = (h_counter == H_LAST);
    frame_wrap = line_wrap && (v_counter == V_LAST);
    h_next     = h_counter;
    v_next     = v_counter;
    if (pix_tick) begin
      h_next = line_wrap ? 16'd0 : h_counter + 16'd1;
      if (line_wrap) begin
        v_next = (v_counter == V_LAST) ? 16'd0 : v_counter + 16'd1;
      end
    end
    h_vis_next = (h_next >= H_ACT_BEG) && (h_next < H_ACT_END);
    v_vis_next = (v_next >= V_ACT_BEG) && (v_next < V_ACT_END);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= 5'd0;
      pix_tick    <= 1'b0;
      h_counter   <= 16'd0;
      v_counter   <= 16'd0;
      hsync       <= SYNC_POL;
      vsync       <= SYNC_POL;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      div_cnt     <= div_next;
      pix_tick    <= (div_next == DIV_LAST);
      h_counter   <= h_next;
      v_counter   <= v_next;
      hsync       <= (h_next < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (v_next < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
      video_on    <= h_vis_next && v_vis_next;
      frame_start <= pix_tick && frame_wrap;
      if (pix_tick && frame_wrap) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule
